// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the DRAM command scheduler: command encodings,
// scheduler state enum and the default geometry/timing constants.
package dram_ctrl_pkg;

    localparam int DEF_NUM_OF_BANKS = 8;
    localparam int DEF_NUM_OF_ROWS  = 128;
    localparam int DEF_NUM_OF_COLS  = 8;

    localparam int DEF_T_RCD  = 2;
    localparam int DEF_T_RP   = 2;
    localparam int DEF_T_CL   = 2;
    localparam int DEF_T_RFC  = 8;
    localparam int DEF_T_REFI = 256;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_PREA = 3'd5,
        CMD_REF  = 3'd6
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRE_W      = 3'd1,
        ST_ACT_W      = 3'd2,
        ST_ACC_W      = 3'd3,
        ST_REF_PREA_W = 3'd4,
        ST_REF_W      = 3'd5
    } state_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter; raises ref_pending on each wrap
// and holds it until the scheduler reports the refresh finished.
module dram_refresh_timer #(
    parameter int T_REFI = 256
) (
    input  logic clk,
    input  logic rst_b,
    input  logic ref_done,
    output logic ref_pending
);

    localparam int CNT_W = (T_REFI > 1) ? $clog2(T_REFI) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(T_REFI - 1);

    logic [CNT_W-1:0] ref_cnt;
    logic             wrap;

    assign wrap = (ref_cnt == LAST);

    // A wrap while a refresh is still outstanding is simply absorbed.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            ref_cnt <= wrap ? '0 : ref_cnt + CNT_W'(1);
            if (ref_done) begin
                ref_pending <= 1'b0;
            end else if (wrap) begin
                ref_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_cmd_sched.sv
// Single-request DRAM command scheduler with open-page tracking and
// periodic all-bank refresh.
//
// state         | meaning
// --------------+--------------------------------------------------
// ST_IDLE       | ready for a request, or starting a due refresh
// ST_PRE_W      | PRE issued for a row conflict, waiting T_RP
// ST_ACT_W      | ACT issued, waiting T_RCD before RD/WR
// ST_ACC_W      | RD/WR issued, waiting T_CL before rsp_valid
// ST_REF_PREA_W | PREA issued ahead of refresh, waiting T_RP
// ST_REF_W      | REF issued, waiting T_RFC
module dram_cmd_sched
    import dram_ctrl_pkg::*;
#(
    parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
    parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
    parameter int NUM_OF_COLS  = DEF_NUM_OF_COLS,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_CL         = DEF_T_CL,
    parameter int T_RFC        = DEF_T_RFC,
    parameter int T_REFI       = DEF_T_REFI,
    localparam int BW          = $clog2(NUM_OF_BANKS),
    localparam int RW          = $clog2(NUM_OF_ROWS),
    localparam int CW          = $clog2(NUM_OF_COLS)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_rw,
    input  logic [BW-1:0] req_bank,
    input  logic [RW-1:0] req_row,
    input  logic [CW-1:0] req_col,
    output logic          cmd_valid,
    output logic [2:0]    cmd,
    output logic [BW-1:0] cmd_bank,
    output logic [RW-1:0] cmd_row,
    output logic [CW-1:0] cmd_col,
    output logic          rsp_valid,
    output logic          busy
);

    localparam int T_MAX = max_of(max_of(T_RCD, T_RP), max_of(T_CL, T_RFC));
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_e                  state;
    logic [TW-1:0]           wait_cnt;
    logic                    acc_rw;
    logic [BW-1:0]           acc_bank;
    logic [RW-1:0]           acc_row;
    logic [CW-1:0]           acc_col;
    logic [NUM_OF_BANKS-1:0] open_valid;
    logic [RW-1:0]           open_row [NUM_OF_BANKS];
    logic                    ref_pending;
    logic                    ref_done;
    logic                    bank_open;
    logic                    row_hit;

    assign req_ready = (state == ST_IDLE) && !ref_pending;
    assign busy      = (state != ST_IDLE);
    assign ref_done  = (state == ST_REF_W) && (wait_cnt == '0);
    assign bank_open = open_valid[req_bank];
    assign row_hit   = bank_open && (open_row[req_bank] == req_row);

    dram_refresh_timer #(
        .T_REFI (T_REFI)
    ) u_refresh_timer (
        .clk         (clk),
        .rst_b       (rst_b),
        .ref_done    (ref_done),
        .ref_pending (ref_pending)
    );

    // Command outputs default to NOP each cycle; only issuing branches override.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            cmd_valid  <= 1'b0;
            cmd        <= CMD_NOP;
            cmd_bank   <= '0;
            cmd_row    <= '0;
            cmd_col    <= '0;
            rsp_valid  <= 1'b0;
            acc_rw     <= 1'b0;
            acc_bank   <= '0;
            acc_row    <= '0;
            acc_col    <= '0;
            open_valid <= '0;
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                open_row[i] <= '0;
            end
        end else begin
            cmd_valid <= 1'b0;
            cmd       <= CMD_NOP;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ref_pending) begin
                        cmd_valid  <= 1'b1;
                        open_valid <= '0;
                        if (|open_valid) begin
                            cmd      <= CMD_PREA;
                            wait_cnt <= TW'(T_RP - 1);
                            state    <= ST_REF_PREA_W;
                        end else begin
                            cmd      <= CMD_REF;
                            wait_cnt <= TW'(T_RFC - 1);
                            state    <= ST_REF_W;
                        end
                    end else if (req_valid) begin
                        acc_rw    <= req_rw;
                        acc_bank  <= req_bank;
                        acc_row   <= req_row;
                        acc_col   <= req_col;
                        cmd_valid <= 1'b1;
                        cmd_bank  <= req_bank;
                        if (row_hit) begin
                            cmd      <= req_rw ? CMD_WR : CMD_RD;
                            cmd_row  <= req_row;
                            cmd_col  <= req_col;
                            wait_cnt <= TW'(T_CL - 1);
                            state    <= ST_ACC_W;
                        end else if (bank_open) begin
                            cmd                  <= CMD_PRE;
                            open_valid[req_bank] <= 1'b0;
                            wait_cnt             <= TW'(T_RP - 1);
                            state                <= ST_PRE_W;
                        end else begin
                            cmd                  <= CMD_ACT;
                            cmd_row              <= req_row;
                            open_valid[req_bank] <= 1'b1;
                            open_row[req_bank]   <= req_row;
                            wait_cnt             <= TW'(T_RCD - 1);
                            state                <= ST_ACT_W;
                        end
                    end
                end
                ST_PRE_W: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - TW'(1);
                    end else begin
                        cmd_valid            <= 1'b1;
                        cmd                  <= CMD_ACT;
                        cmd_bank             <= acc_bank;
                        cmd_row              <= acc_row;
                        open_valid[acc_bank] <= 1'b1;
                        open_row[acc_bank]   <= acc_row;
                        wait_cnt             <= TW'(T_RCD - 1);
                        state                <= ST_ACT_W;
                    end
                end
                ST_ACT_W: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - TW'(1);
                    end else begin
                        cmd_valid <= 1'b1;
                        cmd       <= acc_rw ? CMD_WR : CMD_RD;
                        cmd_bank  <= acc_bank;
                        cmd_row   <= acc_row;
                        cmd_col   <= acc_col;
                        wait_cnt  <= TW'(T_CL - 1);
                        state     <= ST_ACC_W;
                    end
                end
                ST_ACC_W: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - TW'(1);
                    end else begin
                        rsp_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_REF_PREA_W: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - TW'(1);
                    end else begin
                        cmd_valid <= 1'b1;
                        cmd       <= CMD_REF;
                        wait_cnt  <= TW'(T_RFC - 1);
                        state     <= ST_REF_W;
                    end
                end
                ST_REF_W: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - TW'(1);
                    end else begin
                        open_valid <= '0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Bench for dram_cmd_sched: directed timing scenarios plus a randomized run
// checked cycle by cycle against a command-schedule model.
module tb_dram_cmd_sched;
    import dram_ctrl_pkg::*;

    localparam int NB     = 8;
    localparam int T_RCD  = 2;
    localparam int T_RP   = 2;
    localparam int T_CL   = 2;
    localparam int T_RFC  = 8;
    localparam int T_REFI = 64;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_rw = 1'b0;
    logic [2:0]  req_bank = '0;
    logic [6:0]  req_row = '0;
    logic [2:0]  req_col = '0;
    logic        req_ready;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [2:0]  cmd_bank;
    logic [6:0]  cmd_row;
    logic [2:0]  cmd_col;
    logic        rsp_valid;
    logic        busy;
    logic [16:0] cmd_word;

    int cyc;
    int n_checks;
    int n_pass;

    assign cmd_word = {cmd_valid, cmd, cmd_bank, cmd_row, cmd_col};

    always #5 clk = ~clk;

    dram_cmd_sched #(
        .NUM_OF_BANKS (NB),
        .NUM_OF_ROWS  (128),
        .NUM_OF_COLS  (8),
        .T_RCD        (T_RCD),
        .T_RP         (T_RP),
        .T_CL         (T_CL),
        .T_RFC        (T_RFC),
        .T_REFI       (T_REFI)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_bank  (req_bank),
        .req_row   (req_row),
        .req_col   (req_col),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_bank  (cmd_bank),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .rsp_valid (rsp_valid),
        .busy      (busy)
    );

    function automatic logic [16:0] cw(input int op, input int b, input int r, input int c);
        return {(op != 0), 3'(op), 3'(b), 7'(r), 3'(c)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick;
    endtask

    task automatic drive_req(input bit rw, input int b, input int r, input int c);
        req_valid = 1'b1;
        req_rw    = rw;
        req_bank  = 3'(b);
        req_row   = 7'(r);
        req_col   = 3'(c);
    endtask

    task automatic idle_req;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        idle_req;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (cmd_word !== 17'd0) $display("FAIL reset_cmd: got %h want %h", cmd_word, 17'd0); else n_pass++;
        n_checks++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL reset_rsp_busy: got %b want 00", {rsp_valid, busy}); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else n_pass++;
        rst_b = 1'b1;
        cyc = 0;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_closed_bank;
        goto(10);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL closed_ready: got %b want 1", req_ready); else n_pass++;
        drive_req(0, 3, 5, 2);
        tick;
        idle_req;
        n_checks++; if (cmd_word !== cw(1, 3, 5, 0)) $display("FAIL closed_act: got %h want %h", cmd_word, cw(1, 3, 5, 0)); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL closed_busy: got %b want 1", busy); else n_pass++;
        tick;
        n_checks++; if (cmd_word !== 17'd0) $display("FAIL closed_gap_nop: got %h want 0", cmd_word); else n_pass++;
        tick;
        n_checks++; if (cmd_word !== cw(2, 3, 5, 2)) $display("FAIL closed_rd: got %h want %h", cmd_word, cw(2, 3, 5, 2)); else n_pass++;
        tick;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL closed_rsp_early: got %b want 0", rsp_valid); else n_pass++;
        tick;
        n_checks++; if ({rsp_valid, busy, req_ready} !== 3'b101) $display("FAIL closed_rsp: got rsp/busy/ready %b want 101", {rsp_valid, busy, req_ready}); else n_pass++;
    endtask

    task automatic test_page_hit;
        goto(16);
        drive_req(1, 3, 5, 7);
        tick;
        drive_req(1, 5, 1, 1);
        n_checks++; if (cmd_word !== cw(3, 3, 5, 7)) $display("FAIL hit_wr: got %h want %h", cmd_word, cw(3, 3, 5, 7)); else n_pass++;
        tick;
        n_checks++; if ({cmd_word, rsp_valid} !== 18'd0) $display("FAIL hit_ignore_busy_req: got %h want 0", {cmd_word, rsp_valid}); else n_pass++;
        idle_req;
        tick;
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL hit_rsp: got %b want 1", rsp_valid); else n_pass++;
    endtask

    task automatic test_conflict;
        goto(20);
        drive_req(0, 3, 9, 1);
        tick;
        idle_req;
        n_checks++; if (cmd_word !== cw(4, 3, 0, 0)) $display("FAIL conflict_pre: got %h want %h", cmd_word, cw(4, 3, 0, 0)); else n_pass++;
        goto(23);
        n_checks++; if (cmd_word !== cw(1, 3, 9, 0)) $display("FAIL conflict_act: got %h want %h", cmd_word, cw(1, 3, 9, 0)); else n_pass++;
        goto(25);
        n_checks++; if (cmd_word !== cw(2, 3, 9, 1)) $display("FAIL conflict_rd: got %h want %h", cmd_word, cw(2, 3, 9, 1)); else n_pass++;
        goto(27);
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL conflict_rsp: got %b want 1", rsp_valid); else n_pass++;
    endtask

    task automatic test_refresh;
        int low;
        goto(63);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL ref_ready_before_wrap: got %b want 1", req_ready); else n_pass++;
        tick;
        low = 0;
        while (req_ready === 1'b0 && cyc < 90) begin
            low++;
            if (cyc == 65) begin
                n_checks++; if (cmd_word !== cw(5, 0, 0, 0)) $display("FAIL ref_prea: got %h want %h", cmd_word, cw(5, 0, 0, 0)); else n_pass++;
            end
            if (cyc == 67) begin
                n_checks++; if (cmd_word !== cw(6, 0, 0, 0)) $display("FAIL ref_ref: got %h want %h", cmd_word, cw(6, 0, 0, 0)); else n_pass++;
            end
            tick;
        end
        n_checks++; if (low != 11) $display("FAIL ref_ready_low_cycles: got %0d want 11", low); else n_pass++;
        n_checks++; if (cyc != 75) $display("FAIL ref_ready_return: got cycle %0d want 75", cyc); else n_pass++;
        drive_req(0, 3, 9, 4);
        tick;
        idle_req;
        n_checks++; if (cmd_word !== cw(1, 3, 9, 0)) $display("FAIL ref_table_cleared_act: got %h want %h", cmd_word, cw(1, 3, 9, 0)); else n_pass++;
        goto(78);
        n_checks++; if (cmd_word !== cw(2, 3, 9, 4)) $display("FAIL ref_after_rd: got %h want %h", cmd_word, cw(2, 3, 9, 4)); else n_pass++;
        goto(80);
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL ref_after_rsp: got %b want 1", rsp_valid); else n_pass++;
    endtask

    task automatic test_collision;
        goto(127);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL coll_ready_on_wrap: got %b want 1", req_ready); else n_pass++;
        drive_req(0, 3, 9, 6);
        tick;
        idle_req;
        n_checks++; if (cmd_word !== cw(2, 3, 9, 6)) $display("FAIL coll_rd_first: got %h want %h", cmd_word, cw(2, 3, 9, 6)); else n_pass++;
        goto(130);
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL coll_rsp: got %b want 1", rsp_valid); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL coll_ready_blocked: got %b want 0", req_ready); else n_pass++;
        tick;
        n_checks++; if (cmd_word !== cw(5, 0, 0, 0)) $display("FAIL coll_prea: got %h want %h", cmd_word, cw(5, 0, 0, 0)); else n_pass++;
        goto(141);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL coll_ref_done_ready: got %b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_reset_mid;
        goto(145);
        drive_req(0, 1, 4, 0);
        tick;
        idle_req;
        n_checks++; if (cmd_word !== cw(1, 1, 4, 0)) $display("FAIL rstmid_act: got %h want %h", cmd_word, cw(1, 1, 4, 0)); else n_pass++;
        tick;
        rst_b = 1'b0;
        #1;
        n_checks++; if ({cmd_word, rsp_valid, busy} !== 19'd0) $display("FAIL rstmid_outputs: got %h want 0", {cmd_word, rsp_valid, busy}); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        cyc = 0;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rstmid_ready_first: got %b want 1", req_ready); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            tick;
            n_checks++; if ({cmd_word, rsp_valid} !== 18'd0) $display("FAIL rstmid_abandoned c%0d: got %h want 0", cyc, {cmd_word, rsp_valid}); else n_pass++;
        end
        drive_req(0, 1, 4, 0);
        tick;
        idle_req;
        n_checks++; if (cmd_word !== cw(1, 1, 4, 0)) $display("FAIL rstmid_next_act: got %h want %h", cmd_word, cw(1, 1, 4, 0)); else n_pass++;
    endtask

    // Model: each accepted request or refresh expands to a timed list of
    // commands; the controller is idle again at the last scheduled event.
    task automatic test_random;
        logic [16:0] exp_cmd [int];
        bit          exp_rsp [int];
        bit          ov [NB];
        int          orow [NB];
        int          busy_from, busy_until, clear_at, acc, b, r;
        bit          pend, exp_ready, exp_busy, any_open;
        logic [16:0] e_cmd;
        bit          e_rsp;
        idle_req;
        rst_b = 1'b0;
        tick;
        tick;
        rst_b = 1'b1;
        cyc = 0;
        busy_from = 0;
        busy_until = 0;
        clear_at = -1;
        pend = 1'b0;
        foreach (ov[i]) begin
            ov[i] = 1'b0;
            orow[i] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            if (c == clear_at) pend = 1'b0;
            else if (c > 0 && (c % T_REFI) == 0) pend = 1'b1;
            exp_ready = (c >= busy_until) && !pend;
            exp_busy  = (c >= busy_from) && (c < busy_until);
            e_cmd = exp_cmd.exists(c) ? exp_cmd[c] : 17'd0;
            e_rsp = exp_rsp.exists(c);
            n_checks++; if (cmd_word !== e_cmd) $display("FAIL rnd_cmd c%0d: got %h want %h", c, cmd_word, e_cmd); else n_pass++;
            n_checks++; if (rsp_valid !== e_rsp) $display("FAIL rnd_rsp c%0d: got %b want %b", c, rsp_valid, e_rsp); else n_pass++;
            n_checks++; if (req_ready !== exp_ready) $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, exp_ready); else n_pass++;
            n_checks++; if (busy !== exp_busy) $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, exp_busy); else n_pass++;

            req_valid = (c >= 70) && ($urandom_range(0, 3) != 0);
            req_rw    = 1'($urandom_range(0, 1));
            req_bank  = 3'($urandom_range(0, 3));
            req_row   = 7'($urandom_range(0, 3));
            req_col   = 3'($urandom_range(0, 7));
            b = int'(req_bank);
            r = int'(req_row);

            if (exp_ready && req_valid) begin
                acc = c + 1;
                if (!ov[b]) begin
                    exp_cmd[acc] = cw(1, b, r, 0);
                    acc += T_RCD;
                end else if (orow[b] != r) begin
                    exp_cmd[acc] = cw(4, b, 0, 0);
                    exp_cmd[acc + T_RP] = cw(1, b, r, 0);
                    acc += T_RP + T_RCD;
                end
                exp_cmd[acc] = cw(req_rw ? 3 : 2, b, r, int'(req_col));
                exp_rsp[acc + T_CL] = 1'b1;
                ov[b] = 1'b1;
                orow[b] = r;
                busy_from = c + 1;
                busy_until = acc + T_CL;
            end else if (c >= busy_until && pend) begin
                any_open = 1'b0;
                foreach (ov[i]) if (ov[i]) any_open = 1'b1;
                acc = c + 1;
                if (any_open) begin
                    exp_cmd[acc] = cw(5, 0, 0, 0);
                    acc += T_RP;
                end
                exp_cmd[acc] = cw(6, 0, 0, 0);
                busy_from = c + 1;
                busy_until = acc + T_RFC;
                clear_at = busy_until;
                foreach (ov[i]) ov[i] = 1'b0;
            end
            tick;
        end
        idle_req;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        cyc = 0;
        #1;
        test_reset;
        test_closed_bank;
        test_page_hit;
        test_conflict;
        test_refresh;
        test_collision;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dram_cmd_sched.md
DRAM_CMD_SCHED -- requirements
Module: dram_cmd_sched

Interface
REQ-001 SHALL have parameter NUM_OF_BANKS, default 8: bank count; bank id width BW = clog2 = 3.
REQ-002 SHALL have parameter NUM_OF_ROWS, default 128: rows per bank; row id width RW = 7.
REQ-003 SHALL have parameter NUM_OF_COLS, default 8: columns per row; col id width CW = 3.
REQ-004 SHALL have parameters T_RCD=2, T_RP=2, T_CL=2, T_RFC=8 and T_REFI=256, all in clk cycles, each >=1.
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 rst_b  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  L2 access request present.
REQ-008 req_ready  out  1  request accepted when valid and ready are both high.
REQ-009 req_rw  in  1  1 = write, 0 = read.
REQ-010 req_bank / req_row / req_col  in  BW / RW / CW  target address.
REQ-011 cmd_valid  out  1  a DRAM command is issued this cycle.
REQ-012 cmd  out  3  encoding: NOP=0, ACT=1, RD=2, WR=3, PRE=4, PREA=5, REF=6.
REQ-013 cmd_bank / cmd_row / cmd_col  out  BW / RW / CW  command address; zero when not relevant.
REQ-014 rsp_valid  out  1  one-cycle pulse marking completion of the accepted access.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL drive all command and response outputs from registers.
REQ-017 req_ready SHALL equal (state==IDLE) && !ref_pending.
REQ-018 SHALL latch rw, bank, row and col on acceptance at cycle N, and issue the first command at cycle N+1.
REQ-019 Page hit (bank open, same row) SHALL issue RD/WR at N+1.
REQ-020 Bank closed SHALL issue ACT at N+1, then RD/WR at N+1+T_RCD.
REQ-021 Row conflict SHALL issue PRE (bank) at N+1, ACT at N+1+T_RP, and RD/WR at N+1+T_RP+T_RCD.
REQ-022 For RD/WR issued at cycle M, rsp_valid SHALL pulse at M+T_CL, and the FSM SHALL be IDLE in that same cycle.
REQ-023 Between commands, cmd_valid SHALL be 0 and cmd SHALL be NOP.
REQ-024 SHALL keep an open-row table (open_valid, open_row) per bank: ACT sets it, PRE clears that bank, PREA/REF clear all banks.
REQ-025 FSM states SHALL be IDLE, PRE_W, ACT_W, ACC_W, REF_PREA_W and REF_W; each wait state counts its timing parameter down to 0.
REQ-026 The refresh counter SHALL run freely from reset, wrapping at T_REFI-1; on wrap it sets ref_pending.
REQ-027 A wrap that occurs while ref_pending is already set SHALL be dropped, with no queuing.
REQ-028 In IDLE with ref_pending set and any bank open, SHALL issue PREA, wait T_RP, then issue REF.
REQ-029 In IDLE with ref_pending set and no bank open, SHALL issue REF immediately.
REQ-030 After REF, SHALL wait T_RFC, clear ref_pending, and return to IDLE.
REQ-031 A refresh that falls due mid-access SHALL wait until the access completes; the access is never aborted.
REQ-032 If req_valid and a counter wrap coincide in IDLE, the request SHALL be accepted first, with refresh immediately after rsp_valid.
REQ-033 The FSM SHALL ignore req_* signals while req_ready is low.

Reset
REQ-034 While rst_b is low: state=IDLE, cmd=NOP, cmd_valid=0, cmd_* address=0, rsp_valid=0, busy=0, open table cleared, refresh counter=0, ref_pending=0.
REQ-035 A reset mid-operation SHALL abandon the access with no rsp_valid; req_ready=1 in the first cycle after rst_b rises.

Structure
REQ-036 Package dram_ctrl_pkg SHALL hold the cmd encodings, the FSM state enum and the default width/timing constants.
REQ-037 Refresh counter and ref_pending SHALL live in sub-module dram_refresh_timer (ports clk, rst_b, ref_done, ref_pending).

Verification (T_RCD=2, T_RP=2, T_CL=2, T_RFC=8, T_REFI=64)
REQ-038 Closed bank: read bank 3, row 5, col 2 accepted at cycle 10 -> ACT(3,5) at 11, RD(3,5,2) at 13, rsp_valid at 15.
REQ-039 Page hit: write bank 3, row 5, col 7 after REQ-038 -> WR at acceptance+1, rsp_valid 2 cycles later, no ACT.
REQ-040 Conflict: read bank 3, row 9 -> PRE(3) at N+1, ACT(3,9) at N+3, RD at N+5, rsp_valid at N+7.
REQ-041 Refresh: bank 3 open at counter wrap -> PREA, REF 2 cycles later, req_ready low 11 cycles total, table empty afterwards (next access issues ACT).
REQ-042 Collision: req_valid on the wrap cycle -> request served first; PREA issued in the cycle after rsp_valid.
REQ-043 Reset: rst_b low during ACT_W -> no RD and no rsp_valid; outputs at reset values; the following request issues ACT.
